// File: rtl/nios_mem_pkg.sv
// Shared types and helpers for the Nios dual-port on-chip RAM.
// Holds the FSM encoding, parameter legality checks and the byte-merge used on write collisions.
package nios_mem_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } mem_state_e;

    localparam int BYTE_W = 8;

    function automatic bit latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Port A owns a lane whenever its byteenable is set; B fills the rest.
    function automatic logic [BYTE_W-1:0] merge_byte(input logic [BYTE_W-1:0] a_byte,
                                                     input logic              a_en,
                                                     input logic [BYTE_W-1:0] b_byte);
        return a_en ? a_byte : b_byte;
    endfunction

endpackage

// File: rtl/nios_ram_tdp_core.sv
// Behavioural true-dual-port byte-enabled RAM array with old-data read semantics.
// Same-address double writes are folded into port A so only one write per lane lands.
module nios_ram_tdp_core
    import nios_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 10024
) (
    input  logic                  clk,
    input  logic                  a_rd,
    input  logic                  a_we,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic [DATA_W-1:0]     a_rdata,
    input  logic                  b_rd,
    input  logic                  b_we,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W/8-1:0]   b_be,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic [DATA_W-1:0]     b_rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              coll;
    logic [DATA_W-1:0] wa_data;
    logic [NB-1:0]     wa_be;
    logic              wb_en;

    always_comb begin
        coll    = a_we & b_we & (a_addr == b_addr);
        wa_data = a_wdata;
        wa_be   = a_be;
        wb_en   = b_we & ~coll;
        if (coll) begin
            wa_be = a_be | b_be;
            for (int i = 0; i < NB; i++) begin
                wa_data[i*BYTE_W +: BYTE_W] = merge_byte(a_wdata[i*BYTE_W +: BYTE_W], a_be[i],
                                                         b_wdata[i*BYTE_W +: BYTE_W]);
            end
        end
    end

    // Reads sample the array before this edge's writes land, giving old data.
    always_ff @(posedge clk) begin
        if (a_rd) begin
            a_rdata <= mem[a_addr];
        end
        if (b_rd) begin
            b_rdata <= mem[b_addr];
        end
        for (int i = 0; i < NB; i++) begin
            if (a_we && wa_be[i]) begin
                mem[a_addr][i*BYTE_W +: BYTE_W] <= wa_data[i*BYTE_W +: BYTE_W];
            end
            if (wb_en && b_be[i]) begin
                mem[b_addr][i*BYTE_W +: BYTE_W] <= b_wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/nios_onchip_ram_dp.sv
// True-dual-port Avalon-MM on-chip RAM: two slave ports, optional post-reset clear,
// configurable read latency with clock-enable stalls and sticky out-of-range flag.
module nios_onchip_ram_dp
    import nios_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 14,
    parameter int DEPTH          = 10024,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  reset_req,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic                  a_chipselect,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [DATA_W/8-1:0]   a_byteenable,
    input  logic [DATA_W-1:0]     a_writedata,
    output logic                  a_waitrequest,
    output logic [DATA_W-1:0]     a_readdata,
    output logic                  a_readdatavalid,
    input  logic [ADDR_W-1:0]     b_address,
    input  logic                  b_chipselect,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [DATA_W/8-1:0]   b_byteenable,
    input  logic [DATA_W-1:0]     b_writedata,
    output logic                  b_waitrequest,
    output logic [DATA_W-1:0]     b_readdata,
    output logic                  b_readdatavalid,
    output logic                  init_done,
    output logic                  oob_err
);

    localparam int              NB       = DATA_W / 8;
    localparam int              IDX_W    = idx_width(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    if (DATA_W % 8 != 0) begin : g_err_data_w
        $error("nios_onchip_ram_dp: DATA_W must be a multiple of 8");
    end
    if (longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_err_depth
        $error("nios_onchip_ram_dp: DEPTH exceeds 2**ADDR_W");
    end
    if (!latency_ok(READ_LATENCY)) begin : g_err_latency
        $error("nios_onchip_ram_dp: READ_LATENCY must be 1 or 2");
    end

    mem_state_e       state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             oob_err_q, oob_err_d;

    logic [1:0]             vld_p0_q, vld_p0_d;
    logic [1:0]             oob_p0_q, oob_p0_d;
    logic [1:0]             vld_p1_q, vld_p1_d;
    logic [1:0]             vld_p2_q, vld_p2_d;
    logic [1:0][DATA_W-1:0] rdata_p1_q, rdata_p1_d;
    logic [1:0][DATA_W-1:0] rdata_p2_q, rdata_p2_d;

    logic                   ready;
    logic                   wait_c;
    logic [1:0]             cs, rd, wr, acc, rd_acc, wr_acc, oob;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] core_q;

    logic              core_a_rd, core_a_we, core_b_rd, core_b_we;
    logic [IDX_W-1:0]  core_a_addr, core_b_addr;
    logic [NB-1:0]     core_a_be;
    logic [DATA_W-1:0] core_a_wdata;

    always_comb begin
        ready   = (state_q == ST_READY);
        wait_c  = ~(ready & clken & ~reset_req);
        cs      = {b_chipselect, a_chipselect};
        rd      = {b_read, a_read};
        wr      = {b_write, a_write};
        addr[0] = a_address;
        addr[1] = b_address;
        acc     = '0;
        rd_acc  = '0;
        wr_acc  = '0;
        oob     = '0;
        for (int p = 0; p < 2; p++) begin
            oob[p]    = ({1'b0, addr[p]} >= DEPTH_L);
            acc[p]    = cs[p] & (rd[p] | wr[p]) & ~wait_c;
            wr_acc[p] = acc[p] & wr[p];
            rd_acc[p] = acc[p] & rd[p] & ~wr[p];
        end
    end

    // The clear engine borrows port A; no traffic is accepted while it runs.
    always_comb begin
        core_a_rd    = rd_acc[0] & ~oob[0];
        core_a_we    = wr_acc[0] & ~oob[0];
        core_a_addr  = addr[0][IDX_W-1:0];
        core_a_be    = a_byteenable;
        core_a_wdata = a_writedata;
        core_b_rd    = rd_acc[1] & ~oob[1];
        core_b_we    = wr_acc[1] & ~oob[1];
        core_b_addr  = addr[1][IDX_W-1:0];
        if (state_q == ST_CLEAR) begin
            core_a_rd    = 1'b0;
            core_a_we    = clken;
            core_a_addr  = clr_cnt_q;
            core_a_be    = '1;
            core_a_wdata = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (clken) begin
            unique case (state_q)
                ST_RESET: state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
                ST_CLEAR: begin
                    if (clr_cnt_q == LAST_IDX) begin
                        state_d   = ST_READY;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + IDX_W'(1);
                    end
                end
                default:  state_d = ST_READY;
            endcase
        end
    end

    // p0: array read issued; p1: readdata for latency 1; p2: extra output register.
    always_comb begin
        vld_p0_d   = vld_p0_q;
        oob_p0_d   = oob_p0_q;
        vld_p1_d   = vld_p1_q;
        vld_p2_d   = vld_p2_q;
        rdata_p1_d = rdata_p1_q;
        rdata_p2_d = rdata_p2_q;
        oob_err_d  = oob_err_q | (|(acc & oob));
        if (clken) begin
            vld_p0_d = rd_acc;
            oob_p0_d = rd_acc & oob;
            vld_p1_d = vld_p0_q;
            vld_p2_d = vld_p1_q;
            for (int p = 0; p < 2; p++) begin
                if (vld_p0_q[p]) begin
                    rdata_p1_d[p] = oob_p0_q[p] ? '0 : core_q[p];
                end
                if (vld_p1_q[p]) begin
                    rdata_p2_d[p] = rdata_p1_q[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RESET;
            clr_cnt_q  <= '0;
            oob_err_q  <= 1'b0;
            vld_p0_q   <= '0;
            oob_p0_q   <= '0;
            vld_p1_q   <= '0;
            vld_p2_q   <= '0;
            rdata_p1_q <= '0;
            rdata_p2_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            oob_err_q  <= oob_err_d;
            vld_p0_q   <= vld_p0_d;
            oob_p0_q   <= oob_p0_d;
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            rdata_p1_q <= rdata_p1_d;
            rdata_p2_q <= rdata_p2_d;
        end
    end

    nios_ram_tdp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (IDX_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk     (clk),
        .a_rd    (core_a_rd),
        .a_we    (core_a_we),
        .a_addr  (core_a_addr),
        .a_be    (core_a_be),
        .a_wdata (core_a_wdata),
        .a_rdata (core_q[0]),
        .b_rd    (core_b_rd),
        .b_we    (core_b_we),
        .b_addr  (core_b_addr),
        .b_be    (b_byteenable),
        .b_wdata (b_writedata),
        .b_rdata (core_q[1])
    );

    assign a_waitrequest   = wait_c;
    assign b_waitrequest   = wait_c;
    assign a_readdata      = (READ_LATENCY == 2) ? rdata_p2_q[0] : rdata_p1_q[0];
    assign b_readdata      = (READ_LATENCY == 2) ? rdata_p2_q[1] : rdata_p1_q[1];
    assign a_readdatavalid = (READ_LATENCY == 2) ? vld_p2_q[0] : vld_p1_q[0];
    assign b_readdatavalid = (READ_LATENCY == 2) ? vld_p2_q[1] : vld_p1_q[1];
    assign init_done       = ready;
    assign oob_err         = oob_err_q;

endmodule

// File: tb/tb_nios_onchip_ram_dp.sv
// Scoreboard bench for nios_onchip_ram_dp: one latency-1 and one latency-2 instance
// share the same stimulus; a byte-level model predicts every read response.
module tb_nios_onchip_ram_dp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, clken, reset_req;
    logic [1:0]         cs, rd, wr;
    logic [1:0][AW-1:0] addr;
    logic [1:0][3:0]    be;
    logic [1:0][DW-1:0] wd;

    logic [1:0]         wreq [2];
    logic [1:0]         rvld [2];
    logic [1:0][DW-1:0] rdat [2];
    logic               initd [2];
    logic               oobe [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        nios_onchip_ram_dp #(
            .DATA_W (DW), .ADDR_W (AW), .DEPTH (DEPTH),
            .READ_LATENCY (g + 1), .CLEAR_ON_RESET (1)
        ) u_dut (
            .clk (clk), .reset_n (reset_n), .clken (clken), .reset_req (reset_req),
            .a_address (addr[0]), .a_chipselect (cs[0]), .a_read (rd[0]), .a_write (wr[0]),
            .a_byteenable (be[0]), .a_writedata (wd[0]), .a_waitrequest (wreq[g][0]),
            .a_readdata (rdat[g][0]), .a_readdatavalid (rvld[g][0]),
            .b_address (addr[1]), .b_chipselect (cs[1]), .b_read (rd[1]), .b_write (wr[1]),
            .b_byteenable (be[1]), .b_writedata (wd[1]), .b_waitrequest (wreq[g][1]),
            .b_readdata (rdat[g][1]), .b_readdatavalid (rvld[g][1]),
            .init_done (initd[g]), .oob_err (oobe[g])
        );
    end

    typedef struct {
        logic [31:0] d;
        int          e0;
        int          c0;
    } sb_t;

    sb_t         sbq [4][$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] last_rd [2][2];
    int          last_lat [2];
    int          n_chk = 0;
    int          n_err = 0;
    int          cnum = 0;
    int          ecnt = 0;
    bit          tb_ready = 0;
    bit          exp_oob = 0;

    always @(posedge clk) begin
        cnum++;
        if (clken) ecnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Decide acceptance from the bench's own view of waitrequest, then update the model.
    task automatic sb_accept();
        bit  exp_w;
        bit  acc;
        sb_t e;
        exp_w = !tb_ready || !clken || reset_req;
        for (int p = 0; p < 2; p++) begin
            if (cs[p] && (rd[p] || wr[p])) begin
                for (int g = 0; g < 2; g++)
                    chk($sformatf("wait L%0d p%0d", g + 1, p), 32'(wreq[g][p]), 32'(exp_w));
                acc = !exp_w;
                if (acc && rd[p] && !wr[p]) begin
                    e.d  = (addr[p] < AW'(DEPTH)) ? mdl[addr[p]] : 32'h0;
                    e.e0 = ecnt + 1;
                    e.c0 = cnum + 1;
                    for (int g = 0; g < 2; g++) sbq[g*2+p].push_back(e);
                end
                if (acc && addr[p] >= AW'(DEPTH)) exp_oob = 1;
            end
        end
        for (int p = 1; p >= 0; p--) begin
            if (cs[p] && wr[p] && !exp_w && addr[p] < AW'(DEPTH)) begin
                for (int i = 0; i < 4; i++)
                    if (be[p][i]) mdl[addr[p]][i*8 +: 8] = wd[p][i*8 +: 8];
            end
        end
    endtask

    always @(negedge clk) begin : mon
        sb_t e;
        if (reset_n && clken) begin
            for (int g = 0; g < 2; g++) begin
                for (int p = 0; p < 2; p++) begin
                    if (rvld[g][p]) begin
                        if (sbq[g*2+p].size() == 0) begin
                            chk($sformatf("unexpected_valid L%0d p%0d", g + 1, p), 1, 0);
                        end else begin
                            e = sbq[g*2+p].pop_front();
                            chk($sformatf("rdata L%0d p%0d", g + 1, p), rdat[g][p], e.d);
                            chk($sformatf("latency L%0d p%0d", g + 1, p), ecnt - e.e0, g + 1);
                            last_rd[g][p] = rdat[g][p];
                            last_lat[g]   = cnum - e.c0;
                        end
                    end
                end
            end
        end
    end

    task automatic idle();
        cs = '0; rd = '0; wr = '0; addr = '0; be = '0; wd = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
        sb_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) cyc();
    endtask

    task automatic set_p(input int p, input bit r, input bit w, input int a,
                         input logic [3:0] b, input logic [31:0] d);
        cs[p] = 1'b1; rd[p] = r; wr[p] = w; addr[p] = AW'(a); be[p] = b; wd[p] = d;
    endtask

    task automatic op(input int p, input bit r, input bit w, input int a,
                      input logic [3:0] b, input logic [31:0] d);
        set_p(p, r, w, a, b, d);
        cyc();
        idle();
    endtask

    task automatic read_all(input int p);
        for (int i = 0; i < DEPTH; i++) begin
            set_p(p, 1, 0, i, 4'h0, 32'h0);
            cyc();
        end
        idle();
        drain(6);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        tb_ready = 0;
        exp_oob  = 0;
        idle();
        for (int k = 0; k < 4; k++) begin
            chk("sb_empty_before_reset", sbq[k].size(), 0);
            sbq[k].delete();
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_wait", 32'(wreq[g]), 32'h3);
            chk("rst_valid", 32'(rvld[g]), 32'h0);
            chk("rst_rdata_a", rdat[g][0], 32'h0);
            chk("rst_rdata_b", rdat[g][1], 32'h0);
            chk("rst_init_done", 32'(initd[g]), 32'h0);
            chk("rst_oob_err", 32'(oobe[g]), 32'h0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic count_clear();
        int n = 0;
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (wreq[0] == 2'b00) done = 1;
            else n++;
        end
        chk("clear_cycles", n, 17);
        for (int g = 0; g < 2; g++) begin
            chk("init_done", 32'(initd[g]), 32'h1);
            chk("wait_dropped", 32'(wreq[g]), 32'h0);
        end
        for (int k = 0; k < DEPTH; k++) mdl[k] = 32'h0;
        tb_ready = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
        idle();
        for (int k = 0; k < DEPTH; k++) mdl[k] = 32'h0;

        do_reset();
        count_clear();
        read_all(0);

        // Partial byte write over existing data, read back through port B.
        op(0, 0, 1, 5, 4'hF, 32'h11223344);
        op(0, 0, 1, 5, 4'h5, 32'hDEADBEEF);
        op(1, 1, 0, 5, 4'h0, 32'h0);
        drain(5);
        for (int g = 0; g < 2; g++) chk("byte_merge_w5", last_rd[g][1], 32'h11AD33EF);

        op(0, 0, 1, 7, 4'hF, 32'h12345678);
        set_p(0, 0, 1, 7, 4'h3, 32'hAAAAAAAA);
        set_p(1, 0, 1, 7, 4'hF, 32'hBBBBBBBB);
        cyc();
        idle();
        op(1, 1, 0, 7, 4'h0, 32'h0);
        drain(5);
        for (int g = 0; g < 2; g++) chk("dual_write_w7", last_rd[g][1], 32'hBBBBAAAA);
        set_p(0, 0, 1, 7, 4'hF, 32'h0F0F0F0F);
        set_p(1, 1, 0, 7, 4'h0, 32'h0);
        cyc();
        idle();
        drain(5);
        for (int g = 0; g < 2; g++) chk("mixed_old_data", last_rd[g][1], 32'hBBBBAAAA);
        op(0, 1, 0, 7, 4'h0, 32'h0);
        op(0, 1, 1, 8, 4'hF, 32'hCAFEF00D);
        op(0, 1, 0, 8, 4'h0, 32'h0);
        drain(5);

        op(0, 1, 0, 7, 4'h0, 32'h0);
        clken = 1'b0;
        drain(3);
        clken = 1'b1;
        drain(5);
        for (int g = 0; g < 2; g++) chk($sformatf("clken_lat L%0d", g + 1), last_lat[g], g + 4);

        set_p(0, 1, 0, 5, 4'h0, 32'h0);
        cyc();
        reset_req = 1'b1;
        set_p(1, 1, 0, 6, 4'h0, 32'h0);
        drain(2);
        reset_req = 1'b0;
        idle();
        drain(5);

        for (int g = 0; g < 2; g++) chk("oob_clear_before", 32'(oobe[g]), 32'h0);
        op(0, 1, 0, 16, 4'h0, 32'h0);
        drain(5);
        for (int g = 0; g < 2; g++) chk("oob_set", 32'(oobe[g]), 32'h1);
        op(1, 0, 1, 16, 4'hF, 32'hFFFFFFFF);
        read_all(1);
        for (int g = 0; g < 2; g++) chk("oob_sticky", 32'(oobe[g]), 32'h1);

        for (int c = 0; c < 200; c++) begin
            clken     = ($urandom_range(0, 7) != 0);
            reset_req = ($urandom_range(0, 9) == 0);
            for (int p = 0; p < 2; p++) begin
                cs[p]   = ($urandom_range(0, 3) != 0);
                rd[p]   = $urandom_range(0, 1);
                wr[p]   = $urandom_range(0, 1);
                addr[p] = AW'($urandom_range(0, DEPTH + 1));
                be[p]   = 4'($urandom_range(0, 15));
                wd[p]   = $urandom;
            end
            cyc();
        end
        clken = 1'b1;
        reset_req = 1'b0;
        idle();
        drain(6);
        for (int g = 0; g < 2; g++) chk("oob_random", 32'(oobe[g]), 32'(exp_oob));

        for (int i = 0; i < DEPTH; i++) op(0, 0, 1, i, 4'hF, 32'hA5000000 | i);
        drain(4);
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) chk("mid_clear_wait", 32'(wreq[g]), 32'h3);
        do_reset();
        count_clear();
        read_all(0);
        read_all(1);
        for (int g = 0; g < 2; g++) chk("oob_after_reset", 32'(oobe[g]), 32'h0);

        for (int k = 0; k < 4; k++) chk("sb_empty", sbq[k].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/nios_onchip_ram_dp.md
# nios_onchip_ram_dp

Parametrised true-dual-port on-chip RAM for the Nios subsystem: the successor to the single-port fixed-width program/data memory. Two independent Avalon-MM slave ports (A: CPU data master, B: DMA/debug), configurable data width, depth and read latency. Optional hardware clear after reset. Explicit `readdatavalid` pipelining with stall on clock-enable.

## Interface
- `DATA_W`, 32: data width; must be a multiple of 8.
- `ADDR_W`, 14: word-address width.
- `DEPTH`, 10024: number of words; must be ≤ 2^ADDR_W.
- `READ_LATENCY`, 1: accepted read to `readdatavalid`; legal values are 1 or 2 (2 = output register).
- `CLEAR_ON_RESET`, 1: 1 means zero all words after reset before accepting traffic.
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clken`  in  1  global clock enable; low freezes all state.
- `reset_req`  in  1  high blocks new accesses (effective enable = `clken & ~reset_req`).
- `a_address` / `b_address`  in  ADDR_W  word address.
- `a_chipselect` / `b_chipselect`  in  1  port select.
- `a_read` / `b_read`  in  1  read request.
- `a_write` / `b_write`  in  1  write request.
- `a_byteenable` / `b_byteenable`  in  DATA_W/8  byte lanes for writes.
- `a_writedata` / `b_writedata`  in  DATA_W  write data.
- `a_waitrequest` / `b_waitrequest`  out  1  high means the request is not accepted.
- `a_readdata` / `b_readdata`  out  DATA_W  read data.
- `a_readdatavalid` / `b_readdatavalid`  out  1  one-cycle strobe qualifying readdata.
- `init_done`  out  1  high once the clear has finished (or immediately if `CLEAR_ON_RESET`=0).
- `oob_err`  out  1  sticky; set by any access with address ≥ DEPTH.

## Operation
- FSM states: RESET → CLEAR → READY.
  - RESET: held while `reset_n`=0.
  - RESET → CLEAR on the first enabled edge when `CLEAR_ON_RESET`=1; otherwise RESET → READY.
  - CLEAR: a counter steps from 0 to DEPTH-1, writing zero to every byte lane, one word per enabled cycle. Moves to READY after DEPTH-1.
- During RESET and CLEAR, both waitrequests are 1.
- In READY, `waitrequest` = ~(`clken` & ~`reset_req`).
- A request is accepted when chipselect & (read|write) & ~waitrequest.
- Read and write asserted together on a port: the write wins and no readdatavalid is produced.
- Writes update only the enabled byte lanes.
- Read-during-write on the same port returns the old data.
- Mixed-port collision (A writes address X while B reads X): B returns the old data.
- Both ports write the same address in the same cycle: port A's enabled bytes win; B's bytes land only where A's byteenable is 0.
- Out-of-range access (address ≥ DEPTH):
  - Writes are dropped.
  - Reads return 0 with readdatavalid still produced.
  - `oob_err` is set; it clears only on reset.
- Reset asserted mid-CLEAR: the counter returns to 0 and the clear restarts from word 0 after release.
- Reset never alters RAM contents beyond the clear.

## Timing
- Reset values:
  - waitrequest = 1, readdata = 0, readdatavalid = 0, `init_done` = 0, `oob_err` = 0.
  - Per-port valid pipeline flushed.
- Read accepted at edge N: readdata and readdatavalid appear after edge N+READ_LATENCY.
- Throughput: one access per port per cycle.
- `clken`=0 freezes the valid pipeline, readdata and the clear counter. The latency counts enabled edges only.
- `reset_req` blocks new accepts only; reads already in flight still complete.
- With `CLEAR_ON_RESET`=1, `init_done` rises DEPTH+1 enabled cycles after reset release, in the same cycle waitrequest first drops.

## Structure
- Package `nios_mem_pkg`: FSM state enum (`ST_RESET`, `ST_CLEAR`, `ST_READY`), latency legality check, byte-merge function for same-address collisions.
- Sub-module `nios_ram_tdp_core`: behavioural true-dual-port byte-enabled array with registered address and old-data read semantics. It must infer block RAM.
- Top level holds: FSM, clear counter (muxed onto port A), accept logic, valid/readdata pipelines, out-of-range compare.
- Elaboration-time errors for:
  - DATA_W not a multiple of 8;
  - DEPTH > 2^ADDR_W;
  - READ_LATENCY ∉ {1,2}.

## Test plan
- Reset then idle, DEPTH=16, CLEAR_ON_RESET=1 → waitrequest high for 17 enabled cycles; then `init_done`=1; reading all 16 words returns 0x00000000.
- Port A writes 0xDEADBEEF to word 5 with byteenable=0x5 over existing 0x11223344 → a read from port B returns 0x11AD33EF, valid exactly READ_LATENCY cycles after accept (check both latencies).
- Same cycle, A writes 0xAAAAAAAA (be=0x3) and B writes 0xBBBBBBBB (be=0xF) to word 7 → word 7 = 0xBBBBAAAA. B reading word 7 while A writes it returns the previous value.
- `clken` dropped for 3 cycles right after a read accept → readdatavalid is delayed by exactly 3 cycles and data is unchanged. `reset_req` pulse → waitrequest high, in-flight read still completes.
- Read at address DEPTH (16) → readdata 0 with valid, `oob_err`=1 and stays set. A write to 16 leaves words 0–15 unchanged.
- `reset_n` pulsed low at clear counter = 9 → after release the clear restarts, `init_done` is delayed the full 17 cycles, and every word reads 0.
